// File: rtl/xoodyak_textout_drain.sv
// Result drain for xoodyak_build: captures qualifying 192-bit textouts with their
// opmode in a small FIFO and streams each frame to the host MSB word first.
module xoodyak_textout_drain #(
  parameter int DEPTH  = 2,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic [191:0]             textout,
  input  logic                     textout_valid,
  input  logic [5:0]               opmode,
  output logic [WORD_W-1:0]        out_data,
  output logic [5:0]               out_op,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int NWORDS = 192 / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int ENT_W  = 198;

  // Function codes whose textout is a host-visible result.
  function automatic logic is_result_code(input logic [3:0] code);
    case (code)
      4'd4, 4'd5, 4'd6, 4'd8: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ENT_W-1:0]  head_s;
  logic              valid_s, last_s, xfer_s, pop_s;
  logic              qual_s, room_s, push_s, drop_s;
  logic [7:0]        shamt_s;
  logic [191:0]      shifted_s;

  // Handshake and admission decode from registered state and this cycle's inputs.
  always_comb begin
    head_s  = mem_q[rd_ptr_q];
    valid_s = (level_q != '0);
    last_s  = (idx_q == IDX_W'(NWORDS - 1));
    xfer_s  = valid_s & out_ready;
    pop_s   = xfer_s & last_s;
    qual_s  = textout_valid & is_result_code(opmode[3:0]);
    // A pop of the head's last word frees its slot for a push on the same edge.
    room_s  = (level_q < LVL_W'(DEPTH)) | pop_s;
    push_s  = qual_s & room_s;
    drop_s  = qual_s & ~room_s;
  end

  // Next-state for pointers, occupancy, word index, overflow and frame counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      idx_d    = '0;
    end else if (xfer_s) begin
      idx_d    = idx_q + IDX_W'(1);
    end else begin
      idx_d    = idx_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers, FIFO storage included so no stale entry survives reset.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_s) mem_q[wr_ptr_q] <= {opmode, textout};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Host-facing outputs; all derive from registered state only.
  always_comb begin
    shamt_s   = 8'(WORD_W * (NWORDS - 1 - int'(idx_q)));
    shifted_s = head_s[191:0] >> shamt_s;
    out_valid = valid_s;
    if (valid_s) begin
      out_data = shifted_s[WORD_W-1:0];
      out_op   = head_s[197:192];
      out_last = last_s;
    end else begin
      out_data = '0;
      out_op   = 6'd0;
      out_last = 1'b0;
    end
    overflow  = ovf_q;
    level     = level_q;
    frame_cnt = cnt_q;
  end

endmodule

// File: tb/tb_xoodyak_textout_drain.sv
// Bench for xoodyak_textout_drain: directed test-plan steps plus random traffic,
// all checked against a frame-queue reference model.
module tb_xoodyak_textout_drain;

  logic         eph1 = 1'b0;
  logic         reset;
  logic [191:0] textout;
  logic         textout_valid;
  logic [5:0]   opmode;
  logic [31:0]  out_data;
  logic [5:0]   out_op;
  logic         out_last, out_valid, out_ready;
  logic         overflow, clr_overflow;
  logic [1:0]   level;
  logic [15:0]  frame_cnt;

  xoodyak_textout_drain dut (
    .eph1(eph1), .reset(reset), .textout(textout), .textout_valid(textout_valid),
    .opmode(opmode), .out_data(out_data), .out_op(out_op), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .clr_overflow(clr_overflow), .level(level), .frame_cnt(frame_cnt)
  );

  always #5 eph1 = ~eph1;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of whole frames plus the word position in the head.
  logic [197:0] fq [$];
  int           widx;
  logic         m_ovf;
  logic [15:0]  m_cnt;
  logic [31:0]  cap [$];

  localparam logic [191:0] K = 192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30;
  logic [31:0] exp_w [6] = '{32'h87a06d55, 32'h61b0d87c, 32'h20a12db5,
                             32'hd3478325, 32'h8ff75fe5, 32'hd87c0e30};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    widx  = 0;
    m_ovf = 1'b0;
    m_cnt = 16'd0;
  endtask

  task automatic check_outputs();
    logic [191:0] t;
    logic [31:0]  w;
    logic [5:0]   op;
    logic         v, l;
    v = (fq.size() != 0);
    if (v) begin
      t  = fq[0][191:0];
      w  = 32'(t >> (32 * (5 - widx)));
      op = fq[0][197:192];
      l  = (widx == 5);
    end else begin
      w = 32'd0; op = 6'd0; l = 1'b0;
    end
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_data",  64'(out_data),  64'(w));
    chk("out_op",    64'(out_op),    64'(op));
    chk("out_last",  64'(out_last),  64'(l));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("level",     64'(level),     64'(fq.size()));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
  endtask

  task automatic model_update();
    bit qual, xfer, pop, room;
    qual = textout_valid && (opmode[3:0] inside {4'd4, 4'd5, 4'd6, 4'd8});
    xfer = (fq.size() != 0) && out_ready;
    pop  = xfer && (widx == 5);
    room = (fq.size() < 2) || pop;
    if (xfer) widx++;
    if (pop) begin
      widx = 0;
      void'(fq.pop_front());
    end
    if (qual && room) begin
      fq.push_back({opmode, textout});
      m_cnt = m_cnt + 16'd1;
    end
    if (qual && !room) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  task automatic step();
    check_outputs();
    if (out_valid === 1'b1 && out_ready) cap.push_back(out_data);
    model_update();
    @(negedge eph1);
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_cap_k(input string tag);
    chk({tag, "_count"}, 64'(cap.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < cap.size()) chk(tag, 64'(cap[i]), 64'(exp_w[i]));
  endtask

  logic [15:0] cnt0;

  initial begin
    reset = 1'b0; textout = '0; textout_valid = 1'b0; opmode = 6'd0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge eph1);
    @(negedge eph1);
    reset = 1'b1;

    // Basic stream
    textout = K; opmode = 6'h04; textout_valid = 1'b1; out_ready = 1'b1;
    step();
    textout_valid = 1'b0;
    cap.delete();
    repeat (8) step();
    check_cap_k("basic_word");
    chk("basic_cnt", 64'(frame_cnt), 64'd1);
    chk("basic_level", 64'(level), 64'd0);

    // Backpressure: stall five cycles then toggle ready
    out_ready = 1'b0; textout_valid = 1'b1;
    step();
    textout_valid = 1'b0;
    repeat (5) begin
      chk("stall_hold", 64'(out_data), 64'h87a06d55);
      step();
    end
    cap.delete();
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    check_cap_k("bp_word");

    // Filtering of non-result codes
    out_ready = 1'b1;
    foreach (exp_w[i]) begin end
    textout_valid = 1'b1;
    opmode = 6'h00; step();
    opmode = 6'h01; step();
    opmode = 6'h02; step();
    opmode = 6'h03; step();
    opmode = 6'h07; step();
    textout_valid = 1'b0;
    step();
    chk("filt_level", 64'(level), 64'd0);
    chk("filt_cnt", 64'(frame_cnt), 64'd2);
    chk("filt_ovf", 64'(overflow), 64'd0);
    opmode = 6'h16; textout = rnd192(); textout_valid = 1'b1;
    step();
    textout_valid = 1'b0;
    chk("cont_op", 64'(out_op), 64'h16);
    repeat (7) step();
    chk("cont_cnt", 64'(frame_cnt), 64'd3);

    // Overflow: three pushes into a two-entry FIFO while stalled
    out_ready = 1'b0; textout_valid = 1'b1;
    opmode = 6'h04; textout = rnd192(); step();
    opmode = 6'h05; textout = rnd192(); step();
    opmode = 6'h08; textout = rnd192(); step();
    textout_valid = 1'b0;
    step();
    chk("ovf_level", 64'(level), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(frame_cnt), 64'd5);
    clr_overflow = 1'b1; step();
    clr_overflow = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    repeat (14) step();

    // Full with pop of the head's last word and a push on the same edge
    out_ready = 1'b0; textout_valid = 1'b1; opmode = 6'h05;
    textout = rnd192(); step();
    textout = rnd192(); step();
    textout_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    chk("full_last", 64'(out_last), 64'd1);
    cnt0 = frame_cnt;
    textout_valid = 1'b1; opmode = 6'h06; textout = rnd192();
    step();
    textout_valid = 1'b0;
    chk("full_level", 64'(level), 64'd2);
    chk("full_ovf", 64'(overflow), 64'd0);
    chk("full_cnt", 64'(frame_cnt), 64'(cnt0 + 16'd1));
    repeat (14) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      textout_valid = ($urandom_range(0, 2) == 0);
      opmode        = 6'($urandom());
      textout       = rnd192();
      out_ready     = ($urandom_range(0, 3) != 0);
      clr_overflow  = ($urandom_range(0, 15) == 0);
      step();
    end
    textout_valid = 1'b0; clr_overflow = 1'b0; out_ready = 1'b1;
    repeat (14) step();

    // Reset in the middle of a frame
    textout = K; opmode = 6'h08; textout_valid = 1'b1;
    step();
    textout_valid = 1'b0;
    step(); step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    @(negedge eph1);
    reset = 1'b1;
    repeat (4) step();
    textout_valid = 1'b1; opmode = 6'h04;
    step();
    textout_valid = 1'b0;
    cap.delete();
    repeat (8) step();
    check_cap_k("post_rst_word");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
